// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a one-entry skid buffer, forwarding tap and stall counter.
// in_ready is registered, so no combinational path runs from out_ready back to the EX stage.
module ex_mem_skid_reg #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_wb_en,
    input  logic              in_mem_rd,
    input  logic              in_mem_wr,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_wb_en,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              out_zero,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_result,
    output logic [CNT_W-1:0]  stall_cnt
);

    // state    | meaning
    // ST_EMPTY | MAIN and SKID both invalid
    // ST_ONE   | MAIN valid, SKID invalid
    // ST_FULL  | MAIN and SKID valid, in_ready low
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rd;
        logic              wb_en;
        logic              mem_rd;
        logic              mem_wr;
        logic              zero;
    } entry_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    entry_t           r_main;
    entry_t           r_skid;
    entry_t           w_in_entry;
    logic             w_main_valid;
    logic             w_accept;
    logic             w_drain;
    logic             w_ld_main_in;
    logic             w_ld_main_skid;
    logic             w_ld_skid;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_main_valid = (r_state != ST_EMPTY);
    assign w_accept     = in_valid && r_in_ready;
    assign w_drain      = w_main_valid && out_ready;

    always_comb begin
        w_in_entry.result     = in_result;
        w_in_entry.store_data = in_store_data;
        w_in_entry.rd         = in_rd;
        w_in_entry.wb_en      = in_wb_en;
        w_in_entry.mem_rd     = in_mem_rd;
        w_in_entry.mem_wr     = in_mem_wr;
        w_in_entry.zero       = (in_result == '0);
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            // Flush wins over any accept/drain; payloads are left untouched.
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt  = ST_ONE;
                        w_ld_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_ld_skid   = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_state_nxt    = ST_ONE;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
            if (w_ld_main_in) begin
                r_main <= w_in_entry;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign in_ready       = r_in_ready;
    assign out_valid      = w_main_valid;
    assign out_result     = r_main.result;
    assign out_store_data = r_main.store_data;
    assign out_rd         = r_main.rd;
    assign out_wb_en      = r_main.wb_en;
    assign out_mem_rd     = r_main.mem_rd;
    assign out_mem_wr     = r_main.mem_wr;
    assign out_zero       = r_main.zero;
    assign fwd_valid      = w_main_valid && r_main.wb_en && (r_main.rd != '0);
    assign fwd_rd         = r_main.rd;
    assign fwd_result     = r_main.result;
    assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg: a table of per-cycle vectors plus hand sequences
// for reset, stall-counter saturation and asynchronous reset while holding an entry.
module tb_ex_mem_skid_reg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;
    localparam logic [63:0] K_SD = 64'h5A5A_5A5A_5A5A_5A5A;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [REG_W-1:0]  in_rd;
    logic              in_wb_en;
    logic              in_mem_rd;
    logic              in_mem_wr;
    logic [DATA_W-1:0] in_store_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_store_data;
    logic [REG_W-1:0]  out_rd;
    logic              out_wb_en;
    logic              out_mem_rd;
    logic              out_mem_wr;
    logic              out_zero;
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_rd;
    logic [DATA_W-1:0] fwd_result;
    logic [CNT_W-1:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_mem_skid_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_rd(in_rd), .in_wb_en(in_wb_en),
        .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_store_data(in_store_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
        .out_wb_en(out_wb_en), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_zero(out_zero),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_result(fwd_result),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        iv;
        logic [63:0] res;
        logic [4:0]  rd;
        logic        wb;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [63:0] ores;
        logic [4:0]  ord;
        logic        owb;
        logic        oz;
        logic        irdy;
        logic        fv;
        logic [3:0]  stall;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    // mem_rd/mem_wr ride on rd bits and store data on result^K, so payload integrity is visible.
    task automatic drive(input logic iv, input logic [63:0] res, input logic [4:0] rd,
                         input logic wb, input logic ordy, input logic fl);
        in_valid      = iv;
        in_result     = res;
        in_rd         = rd;
        in_wb_en      = wb;
        in_mem_rd     = rd[0];
        in_mem_wr     = rd[1];
        in_store_data = res ^ K_SD;
        out_ready     = ordy;
        flush         = fl;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk("out_valid", i, out_valid, v.ov);
        chk("out_result", i, out_result, v.ores);
        chk("out_store_data", i, out_store_data, v.ores ^ K_SD);
        chk("out_rd", i, out_rd, v.ord);
        chk("out_wb_en", i, out_wb_en, v.owb);
        chk("out_mem_rd", i, out_mem_rd, v.ord[0]);
        chk("out_mem_wr", i, out_mem_wr, v.ord[1]);
        chk("out_zero", i, out_zero, v.oz);
        chk("in_ready", i, in_ready, v.irdy);
        chk("fwd_valid", i, fwd_valid, v.fv);
        chk("fwd_rd", i, fwd_rd, v.ord);
        chk("fwd_result", i, fwd_result, v.ores);
        chk("stall_cnt", i, stall_cnt, v.stall);
    endtask

    initial begin
        //            iv  res                    rd  wb ordy fl | ov ores                   ord owb oz irdy fv stall
        vecs[0]  = '{1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0};
        vecs[1]  = '{1'b0, 64'h0,                   5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 64'h1,                   5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 64'h1,                   5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0};
        vecs[3]  = '{1'b1, 64'h2,                   5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 64'h2,                   5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0};
        vecs[4]  = '{1'b1, 64'h3,                   5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 64'h3,                   5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0};
        vecs[5]  = '{1'b1, 64'h4,                   5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 64'h4,                   5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0};
        vecs[6]  = '{1'b0, 64'h0,                   5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h4,                   5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[7]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0};
        vecs[8]  = '{1'b1, 64'h0,                   5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1};
        vecs[9]  = '{1'b1, 64'h77,                  5'd10,1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2};
        vecs[10] = '{1'b0, 64'h0,                   5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0,                   5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2};
        vecs[11] = '{1'b0, 64'h0,                   5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,                   5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2};
        vecs[12] = '{1'b1, 64'h5,                   5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h5,                   5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};
        vecs[13] = '{1'b1, 64'h6,                   5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 64'h5,                   5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3};
        vecs[14] = '{1'b1, 64'h9,                   5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h5,                   5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3};
        vecs[15] = '{1'b1, 64'h0,                   5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0,                   5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3};
        vecs[16] = '{1'b1, 64'h11,                  5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                   5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd4};
        vecs[17] = '{1'b1, 64'h12,                  5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 64'h12,                  5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4};

        rst_n = 1'b0;
        drive(1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst_out_valid", 0, out_valid, 1'b0);
        chk("rst_in_ready", 0, in_ready, 1'b0);
        chk("rst_fwd_valid", 0, fwd_valid, 1'b0);
        chk("rst_out_zero", 0, out_zero, 1'b0);
        chk("rst_stall_cnt", 0, stall_cnt, 4'd0);
        chk("rst_out_result", 0, out_result, 64'h0);

        // Release between edges; in_ready rises only at the next edge.
        #20;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre", 0, in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_post", 0, in_ready, 1'b1);
        chk("rel_out_valid", 0, out_valid, 1'b0);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].iv, vecs[i].res, vecs[i].rd, vecs[i].wb, vecs[i].ordy, vecs[i].fl);
            @(posedge clk);
            #1;
            check_vec(i, vecs[i]);
        end

        // Hold back-pressure long enough for the 4-bit stall counter to saturate.
        drive(1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("sat_stall_cnt", 0, stall_cnt, 4'd15);
        chk("sat_out_result", 0, out_result, 64'h12);
        chk("sat_out_valid", 0, out_valid, 1'b1);
        @(posedge clk);
        #1;
        chk("sat_stall_hold", 0, stall_cnt, 4'd15);

        // Asynchronous reset while one entry is held, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 0, out_valid, 1'b0);
        chk("arst_stall_cnt", 0, stall_cnt, 4'd0);
        chk("arst_in_ready", 0, in_ready, 1'b0);
        chk("arst_fwd_valid", 0, fwd_valid, 1'b0);
        chk("arst_out_result", 0, out_result, 64'h0);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_rel_in_ready", 0, in_ready, 1'b1);
        chk("arst_rel_out_valid", 0, out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid_reg.md
EX_MEM_SKID_REG -- requirements
Module: ex_mem_skid_reg

Interface
REQ-001 Parameter DATA_W, default 64, ALU result and store-data width.
REQ-002 Parameter REG_W, default 5, destination register index width.
REQ-003 Parameter CNT_W, default 16, stall counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  EX stage presents a valid ALU result.
REQ-007 in_ready  output  1  block can accept an entry this cycle.
REQ-008 in_result  input  DATA_W  ALU output (xnor/and/add etc.).
REQ-009 in_rd  input  REG_W  destination register index.
REQ-010 in_wb_en, in_mem_rd, in_mem_wr  input  1 each  writeback and memory-op controls.
REQ-011 in_store_data  input  DATA_W  store operand.
REQ-012 flush  input  1  synchronous pipeline kill.
REQ-013 out_valid  output  1  MEM stage entry valid.
REQ-014 out_ready  input  1  MEM stage accepts the entry.
REQ-015 out_result, out_store_data  output  DATA_W  registered payload.
REQ-016 out_rd  output  REG_W; out_wb_en, out_mem_rd, out_mem_wr  output  1 each.
REQ-017 out_zero  output  1  registered flag, 1 when out_result == 0.
REQ-018 fwd_valid  output  1; fwd_rd  output  REG_W; fwd_result  output  DATA_W  forwarding path to EX.
REQ-019 stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-020 Storage SHALL be two entries: MAIN (drives out_*) and SKID; each entry holds payload, zero flag and a valid bit.
REQ-021 Accept SHALL occur when in_valid && in_ready at a rising edge; drain SHALL occur when out_valid && out_ready.
REQ-022 in_ready SHALL be registered and equal !SKID.valid; no combinational in-to-out or out_ready-to-in_ready path.
REQ-023 States by (MAIN.valid, SKID.valid): EMPTY(0,0), ONE(1,0), FULL(1,1); (0,1) SHALL be unreachable.
REQ-024 EMPTY + accept -> ONE, entry to MAIN; latency from accept edge to out_valid = 1 cycle.
REQ-025 ONE + accept + drain -> ONE, new entry to MAIN (full throughput, one entry per cycle).
REQ-026 ONE + accept, no drain -> FULL, new entry to SKID, MAIN held unchanged.
REQ-027 ONE + drain, no accept -> EMPTY.
REQ-028 FULL + drain -> ONE, SKID moves to MAIN; no accept possible in FULL (in_ready = 0).
REQ-029 Order SHALL be strictly FIFO; no entry dropped or duplicated except by flush.
REQ-030 While out_valid && !out_ready, all out_* SHALL remain stable.
REQ-031 flush SHALL clear both valid bits at the next edge, overriding any simultaneous accept or drain; in_ready = 1 the following cycle.
REQ-032 out_zero SHALL be computed from in_result on capture and travel with the entry.
REQ-033 fwd_valid = out_valid && out_wb_en && (out_rd != 0); fwd_rd = out_rd; fwd_result = out_result (combinational from MAIN).
REQ-034 stall_cnt SHALL increment each cycle with out_valid && !out_ready, saturating at all-ones; not cleared by flush.
REQ-035 Payload of an invalid entry is don't-care, but out_* SHALL not change while out_valid = 0 unless an entry is captured.

Reset
REQ-036 rst_n low SHALL immediately, regardless of clk, clear MAIN.valid, SKID.valid, stall_cnt and all payload registers to 0.
REQ-037 During reset: out_valid = 0, in_ready = 0, fwd_valid = 0, out_zero = 0; in_ready SHALL rise at the first edge after rst_n deasserts.
REQ-038 Reset asserted mid-transfer SHALL discard both entries; no partial entry visible after release.

Verification
REQ-039 Reset, then single accept in_result=64'hAAAA_BBBB_CCCC_DDDD, rd=3, wb_en=1, out_ready=1 -> out_valid one cycle later with that value, out_zero=0, fwd_valid=1, fwd_rd=3.
REQ-040 Streaming 4 results back-to-back with out_ready=1 -> 4 consecutive out_valid cycles, in order, in_ready constantly 1.
REQ-041 out_ready=0, accept 64'hFFFF_FFFF_FFFF_FFFF then 64'h0 -> FULL, in_ready=0, stall_cnt counts; out_ready=1 -> FFFF... then 0 with out_zero=1, in_ready returns 1.
REQ-042 FULL state plus flush asserted together with out_ready=1 -> both entries gone next cycle, out_valid=0, in_ready=1, stall_cnt unchanged.
REQ-043 rd=0 with wb_en=1 -> out_valid=1 but fwd_valid=0.
REQ-044 Assert rst_n low between clock edges while ONE -> out_valid falls immediately without clock edge; stall_cnt=0.
